// File: rtl/alu_control_sequencer.sv
// rtl/alu_control_sequencer.sv - hardwired fetch/decode/execute control unit for a three-operand ALU datapath (optional: CTRL_SINGLE_STEP_EN)
module alu_control_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic             mem_ready,
    input  logic [31:0]      ir,
    output logic             PCout,
    output logic             Zlowout,
    output logic             MDRout,
    output logic             MARin,
    output logic             Zin,
    output logic             PCin,
    output logic             MDRin,
    output logic             IRin,
    output logic             Yin,
    output logic             IncPC,
    output logic             Read,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             Rin,
    output logic             Rout,
    output logic             ADD,
    output logic             SUB,
    output logic             AND,
    output logic             OR,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_T0        = 4'd1;
    localparam logic [3:0] S_T1        = 4'd2;
    localparam logic [3:0] S_T2        = 4'd3;
    localparam logic [3:0] S_T3        = 4'd4;
    localparam logic [3:0] S_T4        = 4'd5;
    localparam logic [3:0] S_T5        = 4'd6;
    localparam logic [3:0] S_HALTED    = 4'd7;
`ifdef CTRL_SINGLE_STEP_EN
    localparam logic [3:0] S_STEP_WAIT = 4'd8;
`endif

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_NOP  = 5'b01111;
    localparam logic [4:0] OP_HALT = 5'b11011;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [4:0] w_op;
    logic       w_is_add;
    logic       w_is_sub;
    logic       w_is_and;
    logic       w_is_or;
    logic       w_is_alu;
    logic       w_is_nop;
    logic       w_is_halt;
    logic       w_is_illegal;
    logic       w_unused;

    // Register-number fields are consumed by the datapath via Gra/Grb/Grc,
    // and step only matters in the single-step build.
    assign w_unused = &{1'b0, step, ir[26:0]};

    assign w_op         = ir[31:27];
    assign w_is_add     = (w_op == OP_ADD);
    assign w_is_sub     = (w_op == OP_SUB);
    assign w_is_and     = (w_op == OP_AND);
    assign w_is_or      = (w_op == OP_OR);
    assign w_is_alu     = w_is_add | w_is_sub | w_is_and | w_is_or;
    assign w_is_nop     = (w_op == OP_NOP);
    assign w_is_halt    = (w_op == OP_HALT);
    assign w_is_illegal = ~(w_is_alu | w_is_nop | w_is_halt);

    // Next-state selection; run is only looked at in IDLE, T3 exits and T5.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = run ? S_T0 : S_IDLE;
            S_T0:     w_next = S_T1;
            S_T1:     w_next = mem_ready ? S_T2 : S_T1;
            S_T2:     w_next = S_T3;
            S_T3: begin
                if (w_is_alu)
                    w_next = S_T4;
                else if (w_is_halt)
                    w_next = S_HALTED;
                else
`ifdef CTRL_SINGLE_STEP_EN
                    w_next = S_STEP_WAIT;
`else
                    w_next = run ? S_T0 : S_IDLE;
`endif
            end
            S_T4:     w_next = S_T5;
`ifdef CTRL_SINGLE_STEP_EN
            S_T5:     w_next = S_STEP_WAIT;
            S_STEP_WAIT: begin
                if (!run)
                    w_next = S_IDLE;
                else if (step)
                    w_next = S_T0;
                else
                    w_next = S_STEP_WAIT;
            end
`else
            S_T5:     w_next = run ? S_T0 : S_IDLE;
`endif
            S_HALTED: w_next = S_HALTED;
            default:  w_next = S_IDLE;
        endcase
    end

    // State register; reset drops straight to IDLE so the decoded strobes clear at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Retired-instruction counter, bumped as each ALU instruction leaves T5; wraps naturally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            retired <= '0;
        else if (r_state == S_T5)
            retired <= retired + 1'b1;
    end

    // Moore strobe decode from the state register and the latched IR.
    always_comb begin
        PCout   = 1'b0;
        Zlowout = 1'b0;
        MDRout  = 1'b0;
        MARin   = 1'b0;
        Zin     = 1'b0;
        PCin    = 1'b0;
        MDRin   = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        Gra     = 1'b0;
        Grb     = 1'b0;
        Grc     = 1'b0;
        Rin     = 1'b0;
        Rout    = 1'b0;
        ADD     = 1'b0;
        SUB     = 1'b0;
        AND     = 1'b0;
        OR      = 1'b0;
        case (r_state)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                // Operand fetch into Y is pointless for nop/halt/illegal.
                Grb  = w_is_alu;
                Rout = w_is_alu;
                Yin  = w_is_alu;
            end
            S_T4: begin
                Grc  = 1'b1;
                Rout = 1'b1;
                Zin  = 1'b1;
                ADD  = w_is_add;
                SUB  = w_is_sub;
                AND  = w_is_and;
                OR   = w_is_or;
            end
            S_T5: begin
                Zlowout = 1'b1;
                Gra     = 1'b1;
                Rin     = 1'b1;
            end
            default: ;
        endcase
    end

    assign halted  = (r_state == S_HALTED);
    assign illegal = (r_state == S_T3) && w_is_illegal;

endmodule

// File: tb/tb_alu_control_sequencer.sv
// tb/tb_alu_control_sequencer.sv - self-checking bench for alu_control_sequencer
module tb_alu_control_sequencer;

    localparam int CNT_W = 8;

    logic             clock = 1'b0;
    logic             reset;
    logic             run;
    logic             step;
    logic             mem_ready;
    logic [31:0]      ir;
    logic PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read;
    logic Gra, Grb, Grc, Rin, Rout, ADD, SUB, AND, OR;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    alu_control_sequencer #(.CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .run(run), .step(step),
        .mem_ready(mem_ready), .ir(ir),
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin),
        .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .IncPC(IncPC), .Read(Read), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Rin(Rin), .Rout(Rout), .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR),
        .halted(halted), .illegal(illegal), .retired(retired)
    );

    wire [19:0] w_obs = {PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
                         IncPC, Read, Gra, Grb, Grc, Rin, Rout, ADD, SUB, AND, OR};

    localparam logic [19:0] B_PCOUT = 20'd1 << 19;
    localparam logic [19:0] B_ZLOW  = 20'd1 << 18;
    localparam logic [19:0] B_MDROUT= 20'd1 << 17;
    localparam logic [19:0] B_MARIN = 20'd1 << 16;
    localparam logic [19:0] B_ZIN   = 20'd1 << 15;
    localparam logic [19:0] B_PCIN  = 20'd1 << 14;
    localparam logic [19:0] B_MDRIN = 20'd1 << 13;
    localparam logic [19:0] B_IRIN  = 20'd1 << 12;
    localparam logic [19:0] B_YIN   = 20'd1 << 11;
    localparam logic [19:0] B_INCPC = 20'd1 << 10;
    localparam logic [19:0] B_READ  = 20'd1 << 9;
    localparam logic [19:0] B_GRA   = 20'd1 << 8;
    localparam logic [19:0] B_GRB   = 20'd1 << 7;
    localparam logic [19:0] B_GRC   = 20'd1 << 6;
    localparam logic [19:0] B_RIN   = 20'd1 << 5;
    localparam logic [19:0] B_ROUT  = 20'd1 << 4;

    localparam logic [19:0] E_T0 = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
    localparam logic [19:0] E_T1 = B_ZLOW | B_PCIN | B_READ | B_MDRIN;
    localparam logic [19:0] E_T2 = B_MDROUT | B_IRIN;
    localparam logic [19:0] E_T3 = B_GRB | B_ROUT | B_YIN;
    localparam logic [19:0] E_T4 = B_GRC | B_ROUT | B_ZIN;
    localparam logic [19:0] E_T5 = B_ZLOW | B_GRA | B_RIN;

    localparam int K_ALU = 0;
    localparam int K_NOP = 1;
    localparam int K_ILL = 2;
    localparam int K_HLT = 3;

    typedef struct {
        logic [31:0] ir;
        int          waits;
        int          kind;
        logic [3:0]  sel;   // {ADD,SUB,AND,OR} expected in T4
    } vec_t;

    vec_t vt[8];

    logic [CNT_W-1:0] sb_q[$];
    logic [CNT_W-1:0] model;
    logic [CNT_W-1:0] sb_exp;
    logic             seen_t5 = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: one expected count per ALU instruction, checked the cycle after T5.
    always @(negedge clock) begin
        if (seen_t5 && !reset) begin
            if (sb_q.size() == 0)
                chk("sb_underflow", 32'd1, 32'd0);
            else begin
                sb_exp = sb_q.pop_front();
                chk("sb_retired", {{(32-CNT_W){1'b0}}, retired}, {{(32-CNT_W){1'b0}}, sb_exp});
            end
        end
        seen_t5 = !reset && Gra && Rin && Zlowout;
    end

    // Caller guarantees the DUT is in T0 at entry.
    task automatic do_instr(input logic [31:0] iv, input int waits, input int kind,
                            input logic [3:0] sel, input string tag);
        ir = iv;
        mem_ready = (waits == 0);
        chk({tag, "_T0"}, w_obs, E_T0);
        tick();
        for (int i = 0; i <= waits; i++) begin
            if (i == waits) mem_ready = 1'b1;
            chk({tag, "_T1"}, w_obs, E_T1);
            tick();
        end
        chk({tag, "_T2"}, w_obs, E_T2);
        chk({tag, "_T2_ill"}, illegal, 0);
        tick();
        if (kind == K_ALU) begin
            chk({tag, "_T3"}, w_obs, E_T3);
            chk({tag, "_T3_ill"}, illegal, 0);
            model = model + 1'b1;
            sb_q.push_back(model);
            tick();
            chk({tag, "_T4"}, w_obs, E_T4 | {16'd0, sel});
            tick();
            chk({tag, "_T5"}, w_obs, E_T5);
            tick();
        end else begin
            chk({tag, "_T3_quiet"}, w_obs, 20'd0);
            chk({tag, "_T3_ill"}, illegal, (kind == K_ILL) ? 1 : 0);
            tick();
            if (kind != K_HLT) chk({tag, "_after_ill"}, illegal, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{32'h28918000, 0, K_ALU, 4'b0010};
        vt[1] = '{32'h28918000, 3, K_ALU, 4'b0010};
        vt[2] = '{32'h18000000, 0, K_ALU, 4'b1000};
        vt[3] = '{32'h20000000, 1, K_ALU, 4'b0100};
        vt[4] = '{32'h30000000, 0, K_ALU, 4'b0001};
        vt[5] = '{32'h78000000, 0, K_NOP, 4'b0000};
        vt[6] = '{32'hF8000000, 2, K_ILL, 4'b0000};
        vt[7] = '{32'h18400000, 0, K_ALU, 4'b1000};

        reset = 1'b1; run = 1'b0; step = 1'b0; mem_ready = 1'b0; ir = 32'h0;
        model = '0;
        #1;
        chk("rst_strobes", w_obs, 20'd0);
        chk("rst_halted", halted, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_retired", retired, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("idle_no_run", w_obs, 20'd0);
        run = 1'b1;
        tick();

        for (int v = 0; v < 8; v++) begin
            do_instr(vt[v].ir, vt[v].waits, vt[v].kind, vt[v].sel, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d_retired", v), retired, model);
        end

        // Reset landing in the middle of T4.
        ir = 32'h28918000;
        mem_ready = 1'b1;
        tick(); tick(); tick(); tick();
        chk("mid_T4", w_obs, E_T4 | 20'h2);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_strobes", w_obs, 20'd0);
        chk("mid_rst_retired", retired, 0);
        sb_q.delete();
        model = '0;
        run = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick(); tick(); tick();
        chk("post_rst_idle", w_obs, 20'd0);
        run = 1'b1;
        tick();

        // Counter wrap through 2**CNT_W instructions.
        for (int n = 0; n < (1 << CNT_W); n++)
            do_instr(vt[2 + (n % 3)].ir, 0, K_ALU, vt[2 + (n % 3)].sel, "wrap");
        chk("wrap_zero", retired, 0);

        // run dropped mid-instruction: instruction completes, then IDLE.
        run = 1'b0;
        do_instr(32'h28918000, 0, K_ALU, 4'b0010, "rundrop");
        chk("rundrop_idle0", w_obs, 20'd0);
        tick();
        chk("rundrop_idle1", w_obs, 20'd0);
        chk("rundrop_retired", retired, 1);
        run = 1'b1;
        tick();

        do_instr(32'hD8000000, 0, K_HLT, 4'b0000, "halt");
        for (int c = 0; c < 20; c++) begin
            chk("halt_flag", halted, 1);
            chk("halt_strobes", w_obs, 20'd0);
            tick();
        end
        chk("halt_retired", retired, 1);

        tick();
        chk("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_control_sequencer.md
# alu_control_sequencer

Hardwired control unit that sits directly upstream of the CPU datapath and drives its register-transfer control lines. It fetches each instruction, waits on memory, decodes IR, and sequences three-operand ALU instructions (add, sub, and, or) through states T0–T5. It also handles nop and halt, and keeps a retired-instruction count.

## Interface
Parameters:
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clock`  in  1  single system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `run`  in  1  level; permits instruction issue.
- `step`  in  1  single-cycle pulse; used only when `CTRL_SINGLE_STEP_EN` is defined.
- `mem_ready`  in  1  memory read data valid on `MDatain` this cycle.
- `ir`  in  32  current IR contents from the datapath.
- `PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read`  out  1 each  datapath strobes.
- `Gra, Grb, Grc, Rin, Rout`  out  1 each  register-select and enable strobes to the datapath select/encode logic.
- `ADD, SUB, AND, OR`  out  1 each  ALU operation selects; at most one is high.
- `halted`  out  1  high while in HALTED.
- `illegal`  out  1  one-cycle pulse on an undefined opcode.
- `retired`  out  CNT_W  count of completed ALU instructions.

## Operation
- IR fields: opcode `ir[31:27]`, Ra `ir[26:23]`, Rb `ir[22:19]`, Rc `ir[18:15]`. Register numbers are decoded by the datapath through Gra/Grb/Grc.
- Opcodes:
  - add = 5'b00011, sub = 5'b00100, and = 5'b00101, or = 5'b00110: ALU instructions.
  - nop = 5'b01111.
  - halt = 5'b11011.
  - Any other opcode is illegal.
- States: IDLE, T0, T1, T2, T3, T4, T5, HALTED (plus STEP_WAIT when configured).
- State outputs (Moore, decoded from the state register and `ir`; every signal not listed is 0):
  - IDLE, HALTED: all strobes 0.
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
  - T3: Grb, Rout, Yin. These are suppressed for nop, halt and illegal opcodes.
  - T4: Grc, Rout, Zin, plus the one ALU select matching the opcode.
  - T5: Zlowout, Gra, Rin.
- Transitions:
  - IDLE→T0 when `run`=1.
  - T0→T1.
  - T1→T2 when `mem_ready`=1; otherwise stay in T1 with all T1 strobes held.
  - T2→T3.
  - T3:
    - ALU opcode → T4.
    - nop or illegal → T0 if `run`=1, else IDLE.
    - halt → HALTED.
  - T4→T5.
  - T5→T0 if `run`=1, else IDLE.
  - HALTED is left only by `reset`.
- `run` is sampled only in IDLE, at T3 exits, and at T5. Deasserting it mid-instruction lets the current instruction finish.
- `retired` increments by 1 on the T5→next edge. It wraps from all-ones to 0. nop, halt and illegal opcodes do not count.
- `illegal` is high for exactly the one T3 cycle of an illegal opcode.

## Timing
- Reset values: state = IDLE, every strobe output = 0, `halted` = 0, `illegal` = 0, `retired` = 0.
- Reset is asynchronous. Asserting it mid-instruction forces all outputs to 0 immediately, without waiting for an edge.
- Latency:
  - ALU instruction with `mem_ready` tied high: 6 cycles (T0–T5).
  - Each low cycle of `mem_ready` in T1 adds 1 cycle.
  - nop or illegal: 4 cycles.
- IR is valid from the cycle after T2. Opcode decode uses `ir` only in T3–T5.
- Outputs change only after a clock edge or on `reset`. No combinational path runs from `run`, `step` or `mem_ready` to any strobe.

## Configuration
- `CTRL_SINGLE_STEP_EN` defined:
  - Every exit from T5, and every nop/illegal exit from T3, goes to STEP_WAIT instead of T0/IDLE.
  - STEP_WAIT drives all strobes 0.
  - STEP_WAIT→T0 on `step`=1 with `run`=1; STEP_WAIT→IDLE if `run`=0.
  - `step` is ignored in every other state.
- `CTRL_SINGLE_STEP_EN` undefined: STEP_WAIT does not exist, `step` is unused, and transitions are exactly as in Operation.

## Test plan
- **AND instruction:** `reset` pulse, then `run`=1, `mem_ready`=1, `ir`=32'h28918000 from T3 on.
  - Required: strobes match the T0–T5 list exactly.
  - AND high only in T4; Gra high only in T5.
  - `retired`=1 after T5; next state is T0.
- **Memory wait:** `mem_ready` held low for 3 cycles in T1.
  - Required: T1 lasts 4 cycles with Read, MDRin and PCin high throughout.
  - T2 begins the cycle after `mem_ready`=1.
- **Opcode sweep:** `ir` opcodes 00011, 00100, 00110.
  - Required: ADD, SUB, OR respectively in T4; the other three selects stay 0.
- **nop, halt, illegal:**
  - nop (`ir`=32'h78000000): T3→T0, no Yin, `retired` unchanged.
  - halt (`ir`=32'hD8000000): `halted`=1 and stays 1 for 20 cycles with `run`=1.
  - illegal (`ir`=32'hF8000000): `illegal` pulses for 1 cycle.
- **Reset mid-instruction:** `reset` asserted halfway through T4.
  - Required: all strobes 0 before the next edge; `retired`=0; after release, state is IDLE until `run`.
- **Counter and step behaviour:**
  - Preload by running 65535 ALU instructions (`CNT_W`=16); the next T5 wraps `retired` to 0.
  - With `CTRL_SINGLE_STEP_EN` defined: the sequencer holds in STEP_WAIT until a `step` pulse.
